config_chain_driver: RTL and testbench

Serial-side master for the fabric configuration shift chain. Accepts configuration words on a valid/ready stream, shifts them bit-serially into the first tile's `shift_in` under `cen`, then pulses `cset` once so every tile latches its new configuration. It simultaneously captures the bits falling out of the chain tail (`shift_out`) and returns them as read-back words. It sits between the SoC-side loader and the head of the baked-tile configuration chain.

---
 rtl/fabric_cfg_pkg.sv | 25 ++
 rtl/cfg_readback_packer.sv | 59 +++++
 rtl/config_chain_driver.sv | 131 +++++++++++++
 tb/tb_config_chain_driver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration chain.
// Holds the chain-driver FSM state encoding and the per-tile configuration
// bit counts that loaders use to compute the total chain length.
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SET,
    ST_DONE
  } cfg_state_e;

  // Configuration bits held by one tile of each kind.
  localparam int DSB_CONF_WIDTH = 97;
  localparam int CLB_CONF_WIDTH = 64;
  localparam int IOB_CONF_WIDTH = 24;

  // Chain length contributed by a run of identical tiles.
  function automatic int unsigned chain_bits(input int unsigned n_tiles,
                                             input int unsigned tile_w);
    return n_tiles * tile_w;
  endfunction

endpackage

// File: rtl/cfg_readback_packer.sv
// Serial-to-word collector for bits leaving the configuration chain tail.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cen        : chain shift enable; shift_out is sampled when high
//   shift_out  : serial bit from the chain tail
//   flush      : marks the final bit of the load; emits a partial word
//   rd_valid   : one-cycle pulse with a completed word
//   rd_data    : collected word, LSB first, upper bits zero when partial
module cfg_readback_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              shift_out,
  input  logic              flush,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;
  logic              word_full;

  // The accumulator is cleared on every emit, so a short final word is
  // naturally zero-padded.
  always_comb begin
    acc_nxt          = acc;
    acc_nxt[bit_cnt] = shift_out;
  end

  assign word_full = (bit_cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      acc      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (cen) begin
        if (word_full || flush) begin
          rd_valid <= 1'b1;
          rd_data  <= acc_nxt;
          acc      <= '0;
          bit_cnt  <= '0;
        end else begin
          acc     <= acc_nxt;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/config_chain_driver.sv
// Serial master for the fabric configuration shift chain.
// Takes configuration words on a valid/ready stream, shifts them LSB first
// into the chain head under cen, pulses cset once, and returns the bits
// leaving the chain tail as read-back words.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, chain_len  : begin a load of chain_len bits (sampled in IDLE)
//   s_valid/s_ready/s_data : configuration word stream
//   cen, shift_in     : chain shift enable and serial head bit
//   cset              : one-cycle latch pulse to all tiles
//   shift_out         : serial bit from the chain tail
//   rd_valid/rd_data  : read-back word pulse
//   busy, done        : load in progress / one-cycle completion pulse
module config_chain_driver
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              cen,
  output logic              shift_in,
  output logic              cset,
  input  logic              shift_out,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  localparam int WB_W = $clog2(WORD_W) + 1;

  cfg_state_e        state, state_nxt;
  logic [LEN_W-1:0]  bits_left, bits_left_nxt;
  logic [WB_W-1:0]   word_bits, word_bits_nxt;
  logic [WORD_W-1:0] sr, sr_nxt;
  logic              last_bit;

  // cen is a registered decode of the state, so it is high exactly while
  // in SHIFT; the last shifted bit is the one with a single bit left.
  assign last_bit = (state == ST_SHIFT) && (bits_left == LEN_W'(1));

  always_comb begin
    state_nxt     = state;
    bits_left_nxt = bits_left;
    word_bits_nxt = word_bits;
    sr_nxt        = sr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (chain_len != '0) begin
            bits_left_nxt = chain_len;
            state_nxt     = ST_LOAD;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          sr_nxt        = s_data;
          word_bits_nxt = (bits_left >= LEN_W'(WORD_W)) ? WB_W'(WORD_W)
                                                         : bits_left[WB_W-1:0];
          state_nxt     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_nxt        = sr >> 1;
        bits_left_nxt = bits_left - LEN_W'(1);
        word_bits_nxt = word_bits - WB_W'(1);
        if (word_bits == WB_W'(1)) begin
          state_nxt = (bits_left == LEN_W'(1)) ? ST_SET : ST_LOAD;
        end
      end
      ST_SET:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control and registered outputs: each output is the decode of the
  // state being entered, so it is valid in the same cycle as that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bits_left <= '0;
      word_bits <= '0;
      s_ready   <= 1'b0;
      cen       <= 1'b0;
      shift_in  <= 1'b0;
      cset      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bits_left <= bits_left_nxt;
      word_bits <= word_bits_nxt;
      s_ready   <= (state_nxt == ST_LOAD);
      cen       <= (state_nxt == ST_SHIFT);
      shift_in  <= (state_nxt == ST_SHIFT) && sr_nxt[0];
      cset      <= (state_nxt == ST_SET);
      busy      <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT) ||
                   (state_nxt == ST_SET);
      done      <= (state_nxt == ST_DONE);
    end
  end

  // Shift-register data path
  always_ff @(posedge clk) begin
    sr <= sr_nxt;
  end

  cfg_readback_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .shift_out(shift_out),
    .flush    (last_bit),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_config_chain_driver.sv
// Bench for config_chain_driver: a table of loads driven against a
// behavioural chain model, with queues of expected head bits and expected
// read-back words, plus reset checks.
module tb_config_chain_driver;
  import fabric_cfg_pkg::*;

  localparam int WORD_W    = 32;
  localparam int LEN_W     = 20;
  localparam int CHAIN_MAX = 12 * DSB_CONF_WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  chain_len = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [WORD_W-1:0] s_data = '0;
  logic              cen;
  logic              shift_in;
  logic              cset;
  logic              shift_out;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  config_chain_driver #(
    .WORD_W(WORD_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .chain_len(chain_len),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .cen      (cen),
    .shift_in (shift_in),
    .cset     (cset),
    .shift_out(shift_out),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done)
  );

  // Chain model: head at bit 0, tail tapped at the active chain length.
  logic [CHAIN_MAX-1:0] chain;
  logic [CHAIN_MAX-1:0] chain_seed;
  int                   tap = 1;

  assign shift_out = chain[tap-1];

  always @(posedge clk) begin
    if (rst) chain <= chain_seed;
    else if (cen) chain <= {chain[CHAIN_MAX-2:0], shift_in};
  end

  int total = 0;
  int bad   = 0;

  logic [WORD_W-1:0] rbq[$];
  bit                bitq[$];

  typedef struct {
    int len;
    int stall;
    int poke;
    int abort_k;
    int exp_lat;
    int exp_first_cen;
    int exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v);
    logic [WORD_W-1:0]    stim[37];
    logic [WORD_W-1:0]    wd;
    logic [CHAIN_MAX-1:0] snap;
    int nw, widx, rem, nb, idx;
    int cen_cnt, cset_cnt, cset_k, rd_cnt, first_cen, done_k, overlap, bit_err, errs;
    logic busy1;

    nw = (v.len + WORD_W - 1) / WORD_W;
    for (int i = 0; i < 37; i++) stim[i] = $urandom;
    rbq.delete();
    bitq.delete();
    widx = 0; cen_cnt = 0; cset_cnt = 0; cset_k = 0; rd_cnt = 0;
    first_cen = 0; done_k = 0; overlap = 0; bit_err = 0; busy1 = 1'b0;
    snap = '0;

    @(negedge clk);
    if (v.len > 0) tap = v.len;
    // Read-back of this load is whatever the chain holds now, tail first.
    for (int w = 0; w < nw; w++) begin
      wd = '0;
      for (int b = 0; b < WORD_W; b++) begin
        idx = w * WORD_W + b;
        if (idx < v.len) wd[b] = chain[v.len-1-idx];
      end
      rbq.push_back(wd);
    end
    start     = 1'b1;
    chain_len = LEN_W'(v.len);

    for (int k = 1; k <= v.exp_lat + 100 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (cen) begin
        cen_cnt++;
        if (first_cen == 0) first_cen = k;
        if (bitq.size() == 0) bit_err++;
        else if (bitq.pop_front() !== shift_in) bit_err++;
      end
      if (cen && cset) overlap++;
      if (cset) begin
        cset_cnt++;
        cset_k = k;
        snap   = chain;
      end
      if (rd_valid) begin
        rd_cnt++;
        if (rbq.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_extra: got %0h expected no word", rd_data);
        end else begin
          check("rd_data", 64'(rd_data), 64'(rbq.pop_front()));
        end
      end
      if (done) begin
        done_k = k;
        check("busy_at_done", 64'(busy), 64'(0));
      end

      if (k == v.abort_k) begin
        check("abort_in_shift", 64'(cen), 64'(1));
        rst = 1'b1;
        #1;
        check("abort_outputs",
              64'({s_ready, cen, shift_in, cset, busy, done, rd_valid, rd_data}), 64'(0));
        check("abort_no_cset", 64'(cset_cnt), 64'(0));
        start   = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_cset_low", 64'(cset), 64'(0));
        rst = 1'b0;
        rbq.delete();
        bitq.delete();
        return;
      end

      start     = (k == v.poke);
      chain_len = (k == v.poke) ? LEN_W'(5) : LEN_W'(v.len);
      s_valid   = (k > v.stall) && (widx < nw);
      s_data    = (widx < nw) ? stim[widx] : '0;
      if (s_valid && s_ready) begin
        rem = v.len - widx * WORD_W;
        nb  = (rem < WORD_W) ? rem : WORD_W;
        for (int b = 0; b < nb; b++) bitq.push_back(stim[widx][b]);
        widx++;
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;

    if (done_k == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done at %0d", v.exp_lat);
    end
    check("latency", 64'(done_k), 64'(v.exp_lat));
    check("first_cen", 64'(first_cen), 64'(v.exp_first_cen));
    check("cen_count", 64'(cen_cnt), 64'(v.len));
    check("cset_count", 64'(cset_cnt), 64'(v.len != 0));
    check("rd_count", 64'(rd_cnt), 64'(v.exp_rd));
    check("busy_after_start", 64'(busy1), 64'(v.len != 0));
    check("cen_cset_overlap", 64'(overlap), 64'(0));
    check("shift_bits", 64'(bit_err + bitq.size()), 64'(0));
    check("rb_left", 64'(rbq.size()), 64'(0));
    if (v.len != 0) begin
      check("cset_then_done", 64'(cset_k), 64'(done_k - 1));
      errs = 0;
      for (int i = 0; i < v.len; i++) begin
        if (snap[v.len-1-i] !== stim[i/WORD_W][i%WORD_W]) errs++;
      end
      check("chain_contents", 64'(errs), 64'(0));
    end
  endtask

  initial begin
    int full_len;
    full_len = int'(chain_bits(12, DSB_CONF_WIDTH));
    for (int i = 0; i < CHAIN_MAX; i++) chain_seed[i] = 1'($urandom_range(0, 1));

    //          len       stall poke abort lat   1st_cen rd
    vecs[0] = '{full_len, 0,    0,   0,    1203, 2,      37};
    vecs[1] = '{full_len, 0,    0,   0,    1203, 2,      37};
    vecs[2] = '{32,       10,   0,   0,    45,   12,     1};
    vecs[3] = '{0,        0,    0,   0,    1,    0,      0};
    vecs[4] = '{100,      0,    20,  0,    106,  2,      4};
    vecs[5] = '{full_len, 0,    0,   200,  1203, 2,      37};
    vecs[6] = '{full_len, 0,    0,   0,    1203, 2,      37};
    vecs[7] = '{45,       3,    0,   0,    52,   5,      2};

    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_cen", 64'(cen), 64'(0));
    check("rst_shift_in", 64'(shift_in), 64'(0));
    check("rst_cset", 64'(cset), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'(0));

    for (int t = 0; t < 8; t++) begin
      run_load(vecs[t]);
      repeat (3) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
